// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, EXE jump flush and shared-RAM freeze.
// Optional stall/flush statistics counters are enabled by defining HAZARD_STAT_EN.
module hazard_ctrl #(
  parameter int unsigned MEM_WAIT_CYC = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_rreg1,
  input  logic [3:0]  id_rreg2,
  input  logic [3:0]  ex_wreg,
  input  logic [1:0]  ex_controlmem,
  input  logic        ex_jump_taken,
  input  logic        mem_ram_req,
  output logic        pc_keep,
  output logic        ifid_keep,
  output logic        ifid_clear,
  output logic        idexe_keep,
  output logic        idexe_clear,
  output logic        exemem_keep,
  output logic        ctrl_state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam logic [3:0] CntInit = 4'(MEM_WAIT_CYC - 2);

  typedef enum logic {StRun = 1'b0, StMemWait = 1'b1} state_e;

  state_e     r_state;
  logic [3:0] r_cnt;
  logic       w_luse;

  assign w_luse = (ex_controlmem == 2'b01) && (ex_wreg != 4'b1111) &&
                  ((ex_wreg == id_rreg1) || (ex_wreg == id_rreg2));

  assign ctrl_state = r_state;

  always_comb begin
    pc_keep     = 1'b0;
    ifid_keep   = 1'b0;
    ifid_clear  = 1'b0;
    idexe_keep  = 1'b0;
    idexe_clear = 1'b0;
    exemem_keep = 1'b0;
    if (!rst) begin
      pc_keep     = 1'b1;
      ifid_clear  = 1'b1;
      idexe_clear = 1'b1;
    end else begin
      unique case (r_state)
        StRun: begin
          if (mem_ram_req) begin
            pc_keep     = 1'b1;
            ifid_keep   = 1'b1;
            idexe_keep  = 1'b1;
            exemem_keep = 1'b1;
          end else if (ex_jump_taken) begin
            ifid_clear  = 1'b1;
            idexe_clear = 1'b1;
          end else if (w_luse) begin
            pc_keep     = 1'b1;
            ifid_keep   = 1'b1;
            idexe_clear = 1'b1;
          end
        end
        StMemWait: begin
          if (r_cnt != 4'd0) begin
            pc_keep     = 1'b1;
            ifid_keep   = 1'b1;
            idexe_keep  = 1'b1;
            exemem_keep = 1'b1;
          end else if (ex_jump_taken) begin
            ifid_clear  = 1'b1;
            idexe_clear = 1'b1;
          end else if (w_luse) begin
            pc_keep     = 1'b1;
            ifid_keep   = 1'b1;
            idexe_clear = 1'b1;
          end else begin
            // IF lost the RAM this cycle, so a fetch bubble goes into IF/ID.
            pc_keep    = 1'b1;
            ifid_clear = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StRun;
      r_cnt   <= 4'd0;
    end else begin
      unique case (r_state)
        StRun: begin
          if (mem_ram_req) begin
            r_cnt   <= CntInit;
            r_state <= StMemWait;
          end
        end
        StMemWait: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= StRun;
          end
        end
        default: r_state <= StRun;
      endcase
    end
  end

`ifdef HAZARD_STAT_EN
  logic        w_any_keep;
  logic        w_flush;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  assign w_any_keep = pc_keep | ifid_keep | idexe_keep | exemem_keep;
  assign w_flush    = ex_jump_taken &&
                      (((r_state == StRun) && !mem_ram_req) ||
                       ((r_state == StMemWait) && (r_cnt == 4'd0)));

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= 16'h0000;
      r_flush_cnt <= 16'h0000;
    end else begin
      if (w_any_keep && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_flush && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with MEM_WAIT_CYC = 3.
// Output vector order: {pc_keep, ifid_keep, ifid_clear, idexe_keep, idexe_clear, exemem_keep}.
module tb_hazard_ctrl;

`ifdef HAZARD_STAT_EN
  localparam int StatEn = 1;
`else
  localparam int StatEn = 0;
`endif

  localparam logic [5:0] OutIdle   = 6'b000000;
  localparam logic [5:0] OutRst    = 6'b101010;
  localparam logic [5:0] OutFreeze = 6'b110101;
  localparam logic [5:0] OutLuse   = 6'b110010;
  localparam logic [5:0] OutJump   = 6'b001010;
  localparam logic [5:0] OutBubble = 6'b101000;

  logic        clk;
  logic        rst;
  logic [3:0]  id_rreg1;
  logic [3:0]  id_rreg2;
  logic [3:0]  ex_wreg;
  logic [1:0]  ex_controlmem;
  logic        ex_jump_taken;
  logic        mem_ram_req;
  logic        pc_keep;
  logic        ifid_keep;
  logic        ifid_clear;
  logic        idexe_keep;
  logic        idexe_clear;
  logic        exemem_keep;
  logic        ctrl_state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  hazard_ctrl #(
    .MEM_WAIT_CYC(3)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .id_rreg1     (id_rreg1),
    .id_rreg2     (id_rreg2),
    .ex_wreg      (ex_wreg),
    .ex_controlmem(ex_controlmem),
    .ex_jump_taken(ex_jump_taken),
    .mem_ram_req  (mem_ram_req),
    .pc_keep      (pc_keep),
    .ifid_keep    (ifid_keep),
    .ifid_clear   (ifid_clear),
    .idexe_keep   (idexe_keep),
    .idexe_clear  (idexe_clear),
    .exemem_keep  (exemem_keep),
    .ctrl_state   (ctrl_state),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [5:0] exp_outs, input logic exp_state);
    check_val({tag, ".outs"},
              {26'd0, pc_keep, ifid_keep, ifid_clear, idexe_keep, idexe_clear, exemem_keep},
              {26'd0, exp_outs});
    check_val({tag, ".state"}, {31'd0, ctrl_state}, {31'd0, exp_state});
  endtask

  task automatic check_stats(input string tag, input int exp_stall, input int exp_flush);
    check_val({tag, ".stall_cnt"}, {16'd0, stall_cnt}, 32'(StatEn * exp_stall));
    check_val({tag, ".flush_cnt"}, {16'd0, flush_cnt}, 32'(StatEn * exp_flush));
  endtask

  task automatic apply(input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] wr,
                       input logic [1:0] cm, input logic jt, input logic mr);
    id_rreg1      = r1;
    id_rreg2      = r2;
    ex_wreg       = wr;
    ex_controlmem = cm;
    ex_jump_taken = jt;
    mem_ram_req   = mr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    apply(4'hF, 4'hF, 4'hF, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    check_outs("reset", OutRst, 1'b0);
    check_stats("reset", 0, 0);
    next_cycle();
    rst = 1'b1;

    @(negedge clk);
    check_outs("idle", OutIdle, 1'b0);
    next_cycle();

    apply(4'hF, 4'h3, 4'h3, 2'b01, 1'b0, 1'b0);
    @(negedge clk);
    check_outs("luse_rreg2", OutLuse, 1'b0);
    check_stats("luse_pre", 0, 0);
    next_cycle();

    apply(4'hF, 4'h3, 4'h3, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    check_outs("after_luse", OutIdle, 1'b0);
    check_stats("luse_post", 1, 0);
    next_cycle();

    apply(4'hF, 4'h3, 4'h3, 2'b10, 1'b0, 1'b0);
    @(negedge clk);
    check_outs("store_no_luse", OutIdle, 1'b0);
    next_cycle();

    apply(4'hF, 4'h2, 4'hF, 2'b01, 1'b0, 1'b0);
    @(negedge clk);
    check_outs("nodest_load", OutIdle, 1'b0);
    next_cycle();

    apply(4'h5, 4'hF, 4'h5, 2'b01, 1'b0, 1'b0);
    @(negedge clk);
    check_outs("luse_rreg1", OutLuse, 1'b0);
    next_cycle();

    apply(4'h5, 4'hF, 4'h5, 2'b01, 1'b1, 1'b0);
    @(negedge clk);
    check_outs("jump_vs_luse", OutJump, 1'b0);
    check_stats("jump_pre", 2, 0);
    next_cycle();

    apply(4'hF, 4'hF, 4'hF, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    check_outs("after_jump", OutIdle, 1'b0);
    check_stats("jump_post", 2, 1);
    next_cycle();

    // Shared-RAM access: freeze, freeze, release bubble, then RUN.
    apply(4'hF, 4'hF, 4'hF, 2'b00, 1'b0, 1'b1);
    @(negedge clk);
    check_outs("mem_T0", OutFreeze, 1'b0);
    next_cycle();
    @(negedge clk);
    check_outs("mem_T1", OutFreeze, 1'b1);
    next_cycle();
    @(negedge clk);
    check_outs("mem_T2_release", OutBubble, 1'b1);
    next_cycle();
    apply(4'hF, 4'hF, 4'hF, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    check_outs("mem_T3", OutIdle, 1'b0);
    check_stats("mem_post", 5, 1);
    next_cycle();

    // Shared-RAM access with a jump held in EXE.
    apply(4'hF, 4'hF, 4'hF, 2'b00, 1'b1, 1'b1);
    @(negedge clk);
    check_outs("memj_T0", OutFreeze, 1'b0);
    next_cycle();
    @(negedge clk);
    check_outs("memj_T1", OutFreeze, 1'b1);
    next_cycle();
    @(negedge clk);
    check_outs("memj_T2_release", OutJump, 1'b1);
    next_cycle();
    apply(4'hF, 4'hF, 4'hF, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    check_outs("memj_T3", OutIdle, 1'b0);
    check_stats("memj_post", 7, 2);
    next_cycle();

    // Shared-RAM access released with a load-use pending.
    apply(4'h7, 4'hF, 4'h7, 2'b01, 1'b0, 1'b1);
    @(negedge clk);
    check_outs("meml_T0", OutFreeze, 1'b0);
    next_cycle();
    @(negedge clk);
    check_outs("meml_T1", OutFreeze, 1'b1);
    next_cycle();
    @(negedge clk);
    check_outs("meml_T2_release", OutLuse, 1'b1);
    next_cycle();
    apply(4'hF, 4'hF, 4'hF, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    check_outs("meml_T3", OutIdle, 1'b0);
    check_stats("meml_post", 10, 2);
    next_cycle();

    // Reset asserted in the middle of MEM_WAIT.
    apply(4'hF, 4'hF, 4'hF, 2'b00, 1'b0, 1'b1);
    @(negedge clk);
    check_outs("rstw_T0", OutFreeze, 1'b0);
    next_cycle();
    @(negedge clk);
    check_outs("rstw_T1", OutFreeze, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    check_outs("rstw_async", OutRst, 1'b0);
    check_stats("rstw_async", 0, 0);
    next_cycle();
    rst = 1'b1;
    apply(4'hF, 4'hF, 4'hF, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    check_outs("rstw_resume", OutIdle, 1'b0);
    next_cycle();
    @(negedge clk);
    check_outs("rstw_run", OutIdle, 1'b0);
    check_stats("rstw_run", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
